// File: rtl/aes_pkg.sv
// AES-128 shared definitions: S-box, round constants, GF(2^8) helpers.
// Imported by the encrypt core and its round datapath.
package aes_pkg;

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [3:0] ROUNDS = 4'd10;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit 2047-8x, i.e. {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// Start/result bus of the AES-128 encrypt core.
// Master issues blocks; slave is the cipher core.
interface aes_encrypt_if;
  logic [127:0] plaintext;
  logic [127:0] secret;
  logic         we;
  logic [127:0] cipher;
  logic         busy;
  logic         valid;

  modport master (
    output plaintext, secret, we,
    input  cipher, busy, valid
  );

  modport slave (
    input  plaintext, secret, we,
    output cipher, busy, valid
  );
endinterface

// File: rtl/aes_enc_round.sv
// One AES forward round: SubBytes, ShiftRows,
// MixColumns (skipped on the last round), AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] result
);

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
            a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
            a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
            gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
  endfunction

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
  end

  // Row r of output column c comes from input column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-32*c-8*r -: 8] =
        sb[127-32*((c+r)%4)-8*r -: 8];
    end
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  assign result = (last_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encrypt core: one round per clock,
// round keys expanded on the fly from the previous key.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  aes_encrypt_if.slave bus
);

  state_t       state_q, state_d;
  logic [3:0]   round_q;
  logic [127:0] block_q;
  logic [127:0] key_q;
  logic [127:0] cipher_q;
  logic         busy_q;
  logic         valid_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  temp;
  logic [127:0] next_key;
  logic [127:0] round_out;
  logic         round_ok;
  logic         last;

  assign round_ok = (round_q != 4'd0) && (round_q <= ROUNDS);
  assign last     = (round_q == ROUNDS);

  assign {w0, w1, w2, w3} = key_q;

  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]),
                 sbox(w3[7:0]),   sbox(w3[31:24])}
              ^ {rcon(round_q), 24'h000000};

  assign k0 = w0 ^ temp;
  assign k1 = w1 ^ k0;
  assign k2 = w2 ^ k1;
  assign k3 = w3 ^ k2;
  assign next_key = {k0, k1, k2, k3};

  aes_enc_round u_round (
    .state      (block_q),
    .round_key  (next_key),
    .last_round (last),
    .result     (round_out)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.we) state_d = CALC;
      CALC: if (!round_ok || last) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      round_q  <= 4'd0;
      block_q  <= '0;
      key_q    <= '0;
      cipher_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      busy_q  <= (state_d == CALC);
      unique case (state_q)
        IDLE: begin
          if (bus.we) begin
            block_q <= bus.plaintext ^ bus.secret;
            key_q   <= bus.secret;
            round_q <= 4'd1;
          end
        end
        CALC: begin
          if (round_ok) begin
            block_q <= round_out;
            key_q   <= next_key;
            round_q <= round_q + 4'd1;
            if (last) begin
              cipher_q <= round_out;
              valid_q  <= 1'b1;
            end
          end else begin
            round_q <= 4'd0;
          end
        end
      endcase
    end
  end

  assign bus.cipher = cipher_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Bench for aes_encrypt: byte-level AES reference model with
// per-cycle compare, plus FIPS-197 literal vectors.
module tb_aes_encrypt;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clock = 1'b0;
  logic reset;

  aes_encrypt_if bus ();

  aes_encrypt dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miss    = 0;

  logic [7:0] tsbox [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from first principles: GF inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tsbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
               ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] n [16];
    logic [7:0] a [4];
    logic [7:0] t [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t[0] = tsbox[k[13]] ^ rc;
      t[1] = tsbox[k[14]];
      t[2] = tsbox[k[15]];
      t[3] = tsbox[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ t[j];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gf_mul(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[i] = tsbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          n[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = n[4*c+r];
          for (int r = 0; r < 4; r++)
            n[4*c+r] = gf_mul(a[r], 8'h02) ^ gf_mul(a[(r+1)%4], 8'h03)
                     ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = n[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // Transaction model: ten edges of work after each accepted start.
  logic [127:0] m_cipher = '0;
  logic [127:0] m_pend   = '0;
  logic         m_valid  = 1'b0;
  int           m_left   = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cipher = '0;
      m_valid  = 1'b0;
      m_left   = 0;
    end else if (m_left > 0) begin
      m_left  = m_left - 1;
      m_valid = (m_left == 0);
      if (m_left == 0) m_cipher = m_pend;
    end else begin
      m_valid = 1'b0;
      if (bus.we === 1'b1) begin
        m_pend = aes_ref(bus.plaintext, bus.secret);
        m_left = 10;
      end
    end
  end

  always @(negedge clock) begin
    vectors++;
    if (bus.busy !== (m_left != 0) || bus.valid !== m_valid ||
        bus.cipher !== m_cipher) begin
      miss++;
      $display("FAIL cycle_compare t=%0t busy %b need %b valid %b need %b cipher %h need %h",
               $time, bus.busy, (m_left != 0), bus.valid, m_valid,
               bus.cipher, m_cipher);
    end
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] pt,
                           input logic [127:0] key, input logic [127:0] exp,
                           input bit chk_r1, input bit scramble);
    int bc = 0;
    int vc = 0;
    logic [127:0] got = '0;
    bus.plaintext = pt;
    bus.secret    = key;
    bus.we        = 1'b1;
    @(negedge clock);
    bus.we = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (chk_r1 && i == 1) check({name, "_round1"}, dut.block_q, B_R1);
      if (scramble && i == 3) begin
        bus.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.secret    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (bus.busy) bc++;
      if (bus.valid) begin
        vc++;
        got = bus.cipher;
      end
      @(negedge clock);
    end
    check({name, "_busy_cycles"}, 128'(bc), 128'd10);
    check({name, "_valid_cycles"}, 128'(vc), 128'd1);
    check({name, "_cipher"}, got, exp);
  endtask

  initial begin
    int vc;
    int n;
    reset         = 1'b1;
    bus.we        = 1'b0;
    bus.plaintext = '0;
    bus.secret    = '0;
    build_sbox();
    check("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
    check("model_appb", aes_ref(B_PT, B_KEY), B_CT);
    check("model_zero", aes_ref('0, '0), Z_CT);

    repeat (2) @(negedge clock);
    check("reset_cipher", bus.cipher, '0);
    check("reset_busy", 128'(bus.busy), '0);
    check("reset_valid", 128'(bus.valid), '0);
    reset = 1'b0;
    @(negedge clock);

    run_block("c1", C1_PT, C1_KEY, C1_CT, 1'b0, 1'b0);
    run_block("appb", B_PT, B_KEY, B_CT, 1'b1, 1'b0);
    run_block("zero", '0, '0, Z_CT, 1'b0, 1'b1);

    vc = 0;
    for (int i = 0; i < 40; i++) begin
      bus.we        = 1'b1;
      bus.plaintext = (i % 2 == 0) ? C1_PT : B_PT;
      bus.secret    = (i % 2 == 0) ? C1_KEY : B_KEY;
      @(negedge clock);
      if (bus.valid) vc++;
    end
    bus.we = 1'b0;
    check("held_we_valids", 128'(vc), 128'd3);
    repeat (15) @(negedge clock);

    bus.plaintext = C1_PT;
    bus.secret    = C1_KEY;
    bus.we        = 1'b1;
    @(negedge clock);
    bus.we = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_busy", 128'(bus.busy), '0);
    check("async_valid", 128'(bus.valid), '0);
    check("async_cipher", bus.cipher, '0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_block("c1_after_reset", C1_PT, C1_KEY, C1_CT, 1'b0, 1'b0);

    bus.plaintext = B_PT;
    bus.secret    = B_KEY;
    bus.we        = 1'b1;
    @(negedge clock);
    bus.we = 1'b0;
    n = 0;
    while (bus.valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("b2b_first_valid", 128'(bus.valid), 128'd1);
    bus.plaintext = C1_PT;
    bus.secret    = C1_KEY;
    bus.we        = 1'b1;
    @(negedge clock);
    bus.we = 1'b0;
    check("b2b_busy", 128'(bus.busy), 128'd1);
    check("b2b_hold_start", bus.cipher, B_CT);
    repeat (9) @(negedge clock);
    check("b2b_hold_end", bus.cipher, B_CT);
    check("b2b_no_early_valid", 128'(bus.valid), '0);
    @(negedge clock);
    check("b2b_second_valid", 128'(bus.valid), 128'd1);
    check("b2b_second_cipher", bus.cipher, C1_CT);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/aes_encrypt.md
Name: aes_encrypt

Overview:
- Iterative AES-128 forward cipher (FIPS-197): takes a 128-bit plaintext and a 128-bit secret key, produces the 128-bit ciphertext.
- Executes one round per clock and expands the key on the fly, with no precompute phase.
- Encrypting-side counterpart to the inverse-cipher core.
- Sits on the same memory-mapped crypto peripheral path, with the same we/busy start protocol.

Parameters:
- None. Key size is fixed at 128 bits and the round count at 10.

Ports:
clock      input   1    system clock, rising edge
reset      input   1    asynchronous, active-high reset
plaintext  input   128  data block; byte 0 = bits [127:120] (FIPS-197 order)
secret     input   128  cipher key, same byte order
we         input   1    start request
cipher     output  128  ciphertext, held until the next accepted start
busy       output  1    high while an encryption is in flight
valid      output  1    one-cycle pulse when cipher updates

Interface fixed: one clock named clock; reset named reset is asynchronous and active-high.

Behaviour:
- Reset (async assert; release is synchronised externally): state=IDLE, round=0, cipher=0, busy=0, valid=0. Internal state and key registers are cleared to 0.
- States: IDLE, CALC. busy is registered and equals (state==CALC).
- Start: at a rising edge with state==IDLE and we==1, the block performs these updates:
  - stateReg <= plaintext ^ secret
  - keyReg <= secret
  - round <= 1
  - state <= CALC
- we is ignored while busy. plaintext and secret are sampled only at the accept edge and may change afterwards.
- CALC, round r in 1..10, one edge per round:
  - nextKey = expand(keyReg, rcon[r]). Standard word expansion: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}, then w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - stateReg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(stateReg))), nextKey). MixColumns is bypassed when r==10.
  - keyReg <= nextKey; round <= r+1.
- rcon sequence for r = 1..10: 01 02 04 08 10 20 40 80 1b 36.
- Completion: at the edge executing r==10, the block performs these updates:
  - cipher <= round result
  - valid <= 1 for exactly one cycle
  - state <= IDLE; busy falls at that same edge
- Latency: accept edge N; cipher and valid appear after edge N+10.
- The next start can be accepted at edge N+11 (we high during the valid cycle), giving a throughput of 1 block per 11 cycles.
- State layout: column c = bits [127-32c -: 32], row 0 in the MSB of each column.
- ShiftRows rotates row r left by r columns. For example, out col0 row1 = in col1 row1, i.e. o[119:112] = i[87:80].
- MixColumns uses GF(2^8) with polynomial 0x11b: column' = [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] x column.
- Reset mid-operation: immediate abort to the reset values. No valid pulse; the partial result is never exposed on cipher.
- we held high continuously: a new block is accepted on each IDLE edge, so the block self-restarts every 11 cycles.
- round is 4 bits. Values 0 and 11..15 are never used in CALC; if reached they force IDLE (defensive).
- cipher is stable between valid pulses.

Decomposition:
- Package aes_pkg holds:
  - the forward S-box function (256-entry table)
  - rcon lookup function
  - xtime / gmul2 / gmul3 functions
  - the state enum type {IDLE, CALC}
  - localparam ROUNDS = 10
- Sub-module aes_enc_round (combinational): inputs state[127:0], roundKey[127:0], lastRound. Output is the next state (SubBytes, ShiftRows, optional MixColumns, AddRoundKey).
- Key expansion step stays inline in aes_encrypt, using package functions.

Test Plan:
- FIPS-197 C.1: secret 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, we pulse -> after 10 cycles cipher=69c4e0d86a7b0430d8cdb78070b4c55a, valid high exactly 1 cycle, busy high exactly 10 cycles.
- FIPS-197 App. B: secret 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> cipher=3925841d02dc09fbdc118597196a0b32. Check intermediate round-1 state after edge N+1 = a49c7ff2689f352b6b5bea43026a5049.
- All-zero key and plaintext -> cipher=66e94bd4ef8a2c3b884cfa59ca342b2e. Change plaintext/secret to random values mid-CALC -> result unaffected.
- we held high for 40 cycles with alternating vectors from the two cases above -> results valid at cycles N+10, N+21, N+32, each correct for the vector sampled at its accept edge. Extra we while busy is ignored.
- Assert reset at round 5 -> busy, valid and cipher go to 0 asynchronously (before the next edge). After release, start C.1 -> correct result with normal latency.
- Back-to-back: valid cycle coincides with we=1 -> new accept at that edge. The previous cipher stays held until the new valid 10 cycles later.
